// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine bank.
package slot_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/reel_spinner_if.sv
// Spin control in, reel digits and status out.
interface reel_spinner_if;
    import slot_pkg::*;

    logic               spin;
    logic               tick;
    logic [DIGIT_W-1:0] randNum1;
    logic [DIGIT_W-1:0] randNum2;
    logic [DIGIT_W-1:0] randNum3;
    logic [DIGIT_W-1:0] randNum4;
    logic [3:0]         reel_stopped;
    logic               spinning;
    logic               result_valid;

    // Driver side: the button/strobe source that observes the result.
    modport master (
        output spin, tick,
        input  randNum1, randNum2, randNum3, randNum4,
        input  reel_stopped, spinning, result_valid
    );

    // Spinner side.
    modport slave (
        input  spin, tick,
        output randNum1, randNum2, randNum3, randNum4,
        output reel_stopped, spinning, result_valid
    );
endinterface

// File: rtl/reel_spinner_reel_digit.sv
// One reel: a 0..DIGIT_MAX wrap counter with parallel load and advance enable.
module reel_digit
    import slot_pkg::*;
#(
    parameter int DIGIT_MAX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               adv,
    output logic [DIGIT_W-1:0] q
);
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    // Load wins over advance; advance wraps DIGIT_MAX back to 0.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (adv)
            q <= (q == DMAX) ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/reel_spinner.sv
// Four-reel spinner: LFSR seeds the reels on a spin edge, reels cycle on
// tick and stop on a staggered schedule, then a one-cycle result pulse.
module reel_spinner
    import slot_pkg::*;
#(
    parameter int          DIGIT_MAX     = 9,
    parameter int          SPIN_TICKS    = 200,
    parameter int          STAGGER_TICKS = 50,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    reel_spinner_if.slave   bus
);
    localparam int LAST = SPIN_TICKS + 3*STAGGER_TICKS;
    // One spare count above LAST so the post-increment never wraps.
    localparam int CW   = $clog2(LAST + 2);
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    logic [15:0]   lfsr;
    logic          spin_q;
    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [3:0]    stopped;
    logic          spinning_r;
    logic          rv_r;

    logic          spin_rise;
    logic          start;
    logic          run;
    logic [3:0]    in_window;
    logic [3:0]    adv;
    logic [3:0][DIGIT_W-1:0] load_val;
    logic [3:0][DIGIT_W-1:0] q;

    assign spin_rise = bus.spin & ~spin_q;
    // A rise while spinning is ignored, so only IDLE/DONE may (re)start.
    assign start     = spin_rise && (state != SPIN);
    assign run       = (state == SPIN) && bus.tick;

    // Free-running Galois LFSR; nonzero seed keeps it off the all-zero state.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // Spin edge detector; resets high so a button held through reset is inert.
    always_ff @(posedge clk) begin
        if (rst)
            spin_q <= 1'b1;
        else
            spin_q <= bus.spin;
    end

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_reel
            localparam logic [CW-1:0] LIM = CW'(SPIN_TICKS + k*STAGGER_TICKS);
            logic [DIGIT_W-1:0] nib;

            assign nib          = lfsr[4*k +: 4];
            // Nibbles above DIGIT_MAX fold down once (DIGIT_MAX >= 7 keeps this in range).
            assign load_val[k]  = (nib > DMAX) ? DIGIT_W'(nib - DMAX - 1'b1) : nib;
            assign in_window[k] = (tick_cnt < LIM);
            assign adv[k]       = run && in_window[k];

            reel_digit #(.DIGIT_MAX(DIGIT_MAX)) u_reel (
                .clk      (clk),
                .rst      (rst),
                .load     (start),
                .load_val (load_val[k]),
                .adv      (adv[k]),
                .q        (q[k])
            );
        end
    endgenerate

    // Control FSM and stop scheduler; all status outputs registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            stopped    <= 4'hF;
            spinning_r <= 1'b0;
            rv_r       <= 1'b0;
        end else begin
            rv_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (spin_rise) begin
                        state      <= SPIN;
                        tick_cnt   <= '0;
                        stopped    <= 4'h0;
                        spinning_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SPIN: begin
                    if (bus.tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        stopped  <= stopped | ~in_window;
                        if (tick_cnt == CW'(LAST)) begin
                            state      <= DONE;
                            spinning_r <= 1'b0;
                            rv_r       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    spinning_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.randNum1     = q[0];
    assign bus.randNum2     = q[1];
    assign bus.randNum3     = q[2];
    assign bus.randNum4     = q[3];
    assign bus.reel_stopped = stopped;
    assign bus.spinning     = spinning_r;
    assign bus.result_valid = rv_r;
endmodule
